// File: rtl/c2p_axil_pkg.sv
// Shared constants for the C2P AXI4-Lite control register bank.
package c2p_axil_pkg;

    // Byte offsets within the bank; only addr[3:2] select a register.
    localparam logic [3:0] MAP_OFS     = 4'h0;
    localparam logic [3:0] CTRL_OFS    = 4'h4;
    localparam logic [3:0] STATUS_OFS  = 4'h8;
    localparam logic [3:0] VERSION_OFS = 4'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STATUS_PENDING = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_OVERRUN = 2;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/c2p_axil_ctrl_slave.sv
// AXI4-Lite responder for the C2P control bank: MAP register, START handoff
// to the core over valid/ready, and sticky status reporting.
module c2p_axil_ctrl_slave
    import c2p_axil_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [31:0]       map_o,
    output logic              inp_valid_o,
    input  logic              inp_ready_i,
    input  logic              done_i
);

    logic              aw_full, w_full;
    logic [ADDR_W-1:2] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              bvalid_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;
    logic [31:0]       map_q, map_out_q;
    logic              pending_q, done_q, overrun_q;

    // Byte-lane bits of the addresses are ignored by design.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Readies are held low while reset is asserted so no handshake can occur.
    assign s_axi_awready = ~aw_full & ~reset;
    assign s_axi_wready  = ~w_full & ~reset;
    assign s_axi_arready = ~rvalid_q & ~reset;

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;
    assign map_o        = map_out_q;
    assign inp_valid_o  = pending_q;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic        wr_hi_ok, rd_hi_ok;
    logic [3:0]  wr_ofs, rd_ofs;
    logic        wr_map, start_req, w1c_done, w1c_ovr;
    logic [1:0]  wr_resp;
    logic [31:0] map_next;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    assign aw_hs    = s_axi_awvalid & s_axi_awready;
    assign w_hs     = s_axi_wvalid & s_axi_wready;
    assign ar_hs    = s_axi_arvalid & s_axi_arready;
    assign commit   = aw_full & w_full & ~bvalid_q;
    assign wr_ofs   = {aw_addr_q[3:2], 2'b00};
    assign wr_hi_ok = (aw_addr_q[ADDR_W-1:4] == '0);
    assign rd_ofs   = {s_axi_araddr[3:2], 2'b00};
    assign rd_hi_ok = (s_axi_araddr[ADDR_W-1:4] == '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_map    = 1'b0;
        start_req = 1'b0;
        w1c_done  = 1'b0;
        w1c_ovr   = 1'b0;
        wr_resp   = RESP_SLVERR;
        if (commit && wr_hi_ok) begin
            unique case (wr_ofs)
                MAP_OFS: begin
                    wr_map  = 1'b1;
                    wr_resp = RESP_OKAY;
                end
                CTRL_OFS: begin
                    start_req = w_strb_q[0] & w_data_q[0];
                    wr_resp   = RESP_OKAY;
                end
                STATUS_OFS: begin
                    w1c_done = w_strb_q[0] & w_data_q[STATUS_DONE];
                    w1c_ovr  = w_strb_q[0] & w_data_q[STATUS_OVERRUN];
                    // Only a genuine W1C is accepted; anything else hits a read-only register.
                    if (w1c_done || w1c_ovr) wr_resp = RESP_OKAY;
                end
                default: wr_resp = RESP_SLVERR;
            endcase
        end
        map_next = wr_map ? apply_wstrb(map_q, w_data_q, w_strb_q) : map_q;
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (rd_hi_ok) begin
            rd_resp = RESP_OKAY;
            unique case (rd_ofs)
                MAP_OFS:     rd_data = map_q;
                CTRL_OFS:    rd_data = {31'b0, pending_q};
                STATUS_OFS:  rd_data = {29'b0, overrun_q, done_q, pending_q};
                VERSION_OFS: rd_data = VERSION;
                default:     rd_data = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge aclk) begin
        if (reset) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            map_q     <= '0;
            map_out_q <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= s_axi_awaddr[ADDR_W-1:2];
            end

            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            map_q <= map_next;

            // A new START only captures when the previous request has been taken.
            if (start_req && !pending_q) begin
                pending_q <= 1'b1;
                map_out_q <= map_next;
            end else if (pending_q && inp_ready_i) begin
                pending_q <= 1'b0;
            end

            if (start_req && pending_q) overrun_q <= 1'b1;
            else if (w1c_ovr)           overrun_q <= 1'b0;

            // The core's done pulse takes priority over a simultaneous software clear.
            if (done_i)        done_q <= 1'b1;
            else if (w1c_done) done_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_c2p_axil_ctrl_slave.sv
// Directed bench for c2p_axil_ctrl_slave: expected responses are queued at
// issue time and compared when the DUT returns them.
module tb_c2p_axil_ctrl_slave;

    logic        aclk;
    logic        reset;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] map_o;
    logic        inp_valid_o, inp_ready_i, done_i;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    c2p_axil_ctrl_slave dut (
        .aclk          (aclk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .map_o         (map_o),
        .inp_valid_o   (inp_valid_o),
        .inp_ready_i   (inp_ready_i),
        .done_i        (done_i)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Drives AW and W with independent start delays, then checks that the
    // response appears exactly one cycle after the later handshake.
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp,
                             input int aw_dly = 0, input int w_dly = 0, input bit pulse_done = 0);
        bit aw_done = 0;
        bit w_done  = 0;
        int cyc = 0;
        int lat = 0;
        logic [1:0] exp;
        exp_b.push_back(resp);
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_wvalid  = !w_done && (cyc >= w_dly);
            @(negedge aclk);
            if (s_axi_awvalid && s_axi_awready) aw_done = 1;
            if (s_axi_wvalid && s_axi_wready) w_done = 1;
            step();
            cyc++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check({tag, "_hs"}, 64'(aw_done && w_done), 64'd1);
        if (pulse_done) done_i = 1'b1;
        while (!s_axi_bvalid && lat < 20) begin
            step();
            done_i = 1'b0;
            lat++;
        end
        done_i = 1'b0;
        check({tag, "_blat"}, 64'(lat), 64'd1);
        exp = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
        check({tag, "_bresp"}, 64'(s_axi_bresp), 64'(exp));
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input int hold = 0);
        bit hs = 0;
        int cyc = 0;
        logic [33:0] exp;
        logic [31:0] first;
        exp_r.push_back({data, resp});
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!hs && cyc < 50) begin
            @(negedge aclk);
            hs = s_axi_arvalid && s_axi_arready;
            step();
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        check({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'd1);
        exp = (exp_r.size() > 0) ? exp_r.pop_front() : 34'bx;
        check({tag, "_rdata"}, {32'b0, s_axi_rdata, s_axi_rresp} >> 0, 64'(exp));
        first = s_axi_rdata;
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold"}, {31'b0, s_axi_rvalid, s_axi_rdata}, {31'b0, 1'b1, first});
        end
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        check({tag, "_rdone"}, 64'(s_axi_rvalid), 64'd0);
    endtask

    task automatic pulse_inp_ready();
        inp_ready_i = 1'b1;
        step();
        inp_ready_i = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        inp_ready_i   = 1'b0;
        done_i        = 1'b0;
        repeat (3) step();

        check("rst_readies", {61'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd0);
        check("rst_valids", {61'b0, s_axi_bvalid, s_axi_rvalid, inp_valid_o}, 64'd0);
        check("rst_data", {s_axi_rdata, map_o}, 64'd0);
        check("rst_resp", {60'b0, s_axi_bresp, s_axi_rresp}, 64'd0);
        reset = 1'b0;
        step();
        check("post_rst_ready", {61'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'd7);

        // MAP writes followed by START while the core is not ready.
        axi_write("map6", 32'h0, 32'd6, 4'hF, OKAY);
        axi_write("map7", 32'h0, 32'd7, 4'hF, OKAY);
        axi_write("start1", 32'h4, 32'd1, 4'hF, OKAY);
        check("start1_map_o", 64'(map_o), 64'd7);
        check("start1_valid", 64'(inp_valid_o), 64'd1);
        repeat (3) step();
        check("start1_held", {31'b0, inp_valid_o, map_o}, {31'b0, 1'b1, 32'd7});

        // AW leading W, then W leading AW.
        axi_write("aw_first", 32'h0, 32'h11, 4'hF, OKAY, 0, 3);
        axi_read("rd_aw_first", 32'h0, 32'h11, OKAY);
        axi_write("w_first", 32'h0, 32'h22, 4'hF, OKAY, 2, 0);
        axi_read("rd_w_first", 32'h0, 32'h22, OKAY);

        // START while pending: overrun, snapshot untouched.
        axi_write("map9", 32'h0, 32'd9, 4'hF, OKAY);
        axi_write("start_ovr", 32'h4, 32'd1, 4'hF, OKAY);
        check("ovr_map_o", 64'(map_o), 64'd7);
        axi_read("rd_status5", 32'h8, 32'h5, OKAY);
        axi_read("rd_ctrl", 32'h4, 32'h1, OKAY);
        pulse_inp_ready();
        check("pend_clear", 64'(inp_valid_o), 64'd0);
        axi_write("start2", 32'h4, 32'd1, 4'hF, OKAY);
        check("start2_map_o", {31'b0, inp_valid_o, map_o}, {31'b0, 1'b1, 32'd9});
        pulse_inp_ready();
        axi_write("w1c_ovr", 32'h8, 32'h4, 4'hF, OKAY);
        axi_read("rd_status0", 32'h8, 32'h0, OKAY);

        // Byte strobes.
        axi_write("map0", 32'h0, 32'h0, 4'hF, OKAY);
        axi_write("map_strb", 32'h0, 32'hAABB_CCDD, 4'b0010, OKAY);
        axi_read("rd_strb", 32'h0, 32'h0000_CC00, OKAY);

        // done pulse coinciding with a W1C of done: the set wins.
        axi_write("w1c_race", 32'h8, 32'h2, 4'hF, OKAY, 0, 0, 1);
        axi_read("rd_done_set", 32'h8, 32'h2, OKAY);
        axi_write("w1c_done", 32'h8, 32'h2, 4'hF, OKAY);
        axi_read("rd_done_clr", 32'h8, 32'h0, OKAY);

        // Error responses and read hold.
        axi_read("rd_version", 32'hC, 32'h0001_0000, OKAY);
        axi_read("rd_unmapped", 32'h10, 32'h0, SLVERR);
        axi_write("wr_version", 32'hC, 32'h1, 4'hF, SLVERR);
        axi_write("wr_status_ro", 32'h8, 32'h1, 4'hF, SLVERR);
        axi_write("wr_hi_addr", 32'h100, 32'h1234, 4'hF, SLVERR);
        axi_read("rd_map_hold", 32'h0, 32'h0000_CC00, OKAY, 5);

        // Reset while a write response is outstanding.
        s_axi_bready = 1'b0;
        axi_write("wr_pre_rst", 32'h0, 32'h55, 4'hF, OKAY);
        step();
        check("bvalid_held", 64'(s_axi_bvalid), 64'd1);
        reset = 1'b1;
        step();
        check("bvalid_rst", 64'(s_axi_bvalid), 64'd0);
        reset = 1'b0;
        s_axi_bready = 1'b1;
        step();
        axi_read("rd_map_rst", 32'h0, 32'h0, OKAY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
